// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mult_share_arbiter
// Brief  : Round-robin sharing of one pipelined unsigned multiplier among
//          NREQ valid/ready requesters, with id-tagged results.
// Rev    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*WIDTH-1:0]     i_req_a,
    input  logic [NREQ*WIDTH-1:0]     i_req_b,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic                      i_stall,
    output logic                      o_res_valid,
    output logic [$clog2(NREQ)-1:0]   o_res_id,
    output logic [2*WIDTH-1:0]        o_res_prod,
    output logic                      o_busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = 2 * WIDTH;

    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_gid;
    logic             w_xfer;
    logic [NREQ-1:0]  w_grant;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [IDW-1:0]   w_ptr_nxt;

    logic             w_tail_v;
    logic [IDW-1:0]   w_tail_id;
    logic [PW-1:0]    w_tail_prod;
    logic             w_stage_busy;

    logic             r_res_valid;
    logic [IDW-1:0]   r_res_id;
    logic [PW-1:0]    r_res_prod;

    // Scan offsets from high to low so the smallest offset from r_ptr wins.
    always_comb begin : p_arb
        int idx;
        idx    = 0;
        w_gid  = '0;
        w_xfer = 1'b0;
        if (!i_stall) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (int'(r_ptr) + k) % NREQ;
                if (i_req_valid[idx]) begin
                    w_gid  = IDW'(idx);
                    w_xfer = 1'b1;
                end
            end
        end
        w_grant = NREQ'(w_xfer) << w_gid;
    end

    assign w_sel_a   = i_req_a[w_gid*WIDTH +: WIDTH];
    assign w_sel_b   = i_req_b[w_gid*WIDTH +: WIDTH];
    assign w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign w_tail_v     = w_xfer;
            assign w_tail_id    = w_gid;
            assign w_tail_prod  = PW'(w_sel_a) * PW'(w_sel_b);
            assign w_stage_busy = 1'b0;
        end else begin : g_latn
            logic             r_s1_v;
            logic [IDW-1:0]   r_s1_id;
            logic [WIDTH-1:0] r_s1_a;
            logic [WIDTH-1:0] r_s1_b;
            logic [PW-1:0]    w_s1_prod;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_v  <= 1'b0;
                    r_s1_id <= '0;
                    r_s1_a  <= '0;
                    r_s1_b  <= '0;
                end else if (!i_stall) begin
                    r_s1_v <= w_xfer;
                    if (w_xfer) begin
                        r_s1_id <= w_gid;
                        r_s1_a  <= w_sel_a;
                        r_s1_b  <= w_sel_b;
                    end
                end
            end

            assign w_s1_prod = PW'(r_s1_a) * PW'(r_s1_b);

            if (LAT == 2) begin : g_direct
                assign w_tail_v     = r_s1_v;
                assign w_tail_id    = r_s1_id;
                assign w_tail_prod  = w_s1_prod;
                assign w_stage_busy = r_s1_v;
            end else begin : g_carry
                localparam int D = LAT - 2;
                logic [D-1:0]   r_cv;
                logic [IDW-1:0] r_cid   [D];
                logic [PW-1:0]  r_cprod [D];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cv <= '0;
                        for (int k = 0; k < D; k++) begin
                            r_cid[k]   <= '0;
                            r_cprod[k] <= '0;
                        end
                    end else if (!i_stall) begin
                        r_cv[0]    <= r_s1_v;
                        r_cid[0]   <= r_s1_id;
                        r_cprod[0] <= w_s1_prod;
                        for (int k = 1; k < D; k++) begin
                            r_cv[k]    <= r_cv[k-1];
                            r_cid[k]   <= r_cid[k-1];
                            r_cprod[k] <= r_cprod[k-1];
                        end
                    end
                end

                assign w_tail_v     = r_cv[D-1];
                assign w_tail_id    = r_cid[D-1];
                assign w_tail_prod  = r_cprod[D-1];
                assign w_stage_busy = r_s1_v | (|r_cv);
            end
        end
    endgenerate

    // Result fields only update on a valid result so they hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_prod  <= '0;
        end else if (!i_stall) begin
            r_res_valid <= w_tail_v;
            if (w_tail_v) begin
                r_res_id   <= w_tail_id;
                r_res_prod <= w_tail_prod;
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_res_prod  = r_res_prod;
    assign o_busy      = w_stage_busy | r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mult_share_arbiter
// Brief  : Directed bench with arbitration model and latency-aware scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  op_a [4];
    logic [7:0]  op_b [4];
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        stall;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_prod;
    logic        busy;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .i_stall     (stall),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .o_res_prod  (res_prod),
        .o_busy      (busy)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   nassert = 0;
    int   nfail   = 0;
    int   ecnt    = 0;   // counts only non-stalled cycles
    int   mptr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs mid-cycle, predict the grant, advance.
    task automatic step(input string tag);
        int         g;
        logic [3:0] exp_rdy;
        logic       exp_rv;
        logic       st;
        @(negedge clk);
        st     = stall;
        exp_rv = (sbq.size() > 0) && (sbq[0].due == ecnt);
        chk({tag, "/busy"}, 32'(busy), 32'(sbq.size() > 0));
        chk({tag, "/res_valid"}, 32'(res_valid), 32'(exp_rv));
        if (exp_rv && !st) begin
            chk({tag, "/res_id"}, 32'(res_id), 32'(sbq[0].id));
            chk({tag, "/res_prod"}, 32'(res_prod), 32'(sbq[0].prod));
            void'(sbq.pop_front());
        end
        g       = st ? -1 : model_grant(req_valid, mptr);
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        chk({tag, "/req_ready"}, 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            sbq.push_back('{id: 2'(g), prod: 16'(op_a[g]) * 16'(op_b[g]), due: ecnt + LAT});
            mptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        if (!st) ecnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'd0;
            op_b[i] = 8'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst/res_valid", 32'(res_valid), 0);
        chk("rst/res_id", 32'(res_id), 0);
        chk("rst/res_prod", 32'(res_prod), 0);
        chk("rst/busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Full contention: grants rotate 0,1,2,3 twice
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'(i + 1);
            op_b[i] = 8'd10;
        end
        req_valid = 4'b1111;
        repeat (8) step("contend");
        req_valid = 4'b0000;
        repeat (3) step("contend_drain");

        // Single request from requester 0
        op_a[0] = 8'd12; op_b[0] = 8'd13;
        req_valid = 4'b0001;
        step("single");
        req_valid = 4'b0000;
        repeat (4) step("single_drain");

        // Operand boundaries
        op_a[1] = 8'd255; op_b[1] = 8'd255; req_valid = 4'b0010; step("max");
        op_a[2] = 8'd0;   op_b[2] = 8'd200; req_valid = 4'b0100; step("zero");
        op_a[3] = 8'd1;   op_b[3] = 8'd255; req_valid = 4'b1000; step("one");
        req_valid = 4'b0000;
        repeat (3) step("bound_drain");

        // Stall for three cycles after the second transfer
        op_a[0] = 8'd3; op_b[0] = 8'd4;
        op_a[1] = 8'd5; op_b[1] = 8'd6;
        op_a[2] = 8'd7; op_b[2] = 8'd8;
        op_a[3] = 8'd9; op_b[3] = 8'd10;
        req_valid = 4'b0111; step("stall_pre0");
        req_valid = 4'b0110; step("stall_pre1");
        stall = 1'b1; req_valid = 4'b1100;
        repeat (3) step("stall");
        stall = 1'b0;
        step("stall_post2");
        req_valid = 4'b1000; step("stall_post3");
        req_valid = 4'b0000;
        repeat (4) step("stall_drain");

        // Asynchronous reset with two operations in flight
        op_a[1] = 8'd11; op_b[1] = 8'd3;
        op_a[2] = 8'd2;  op_b[2] = 8'd9;
        req_valid = 4'b0110; step("inflight1");
        req_valid = 4'b0100; step("inflight2");
        req_valid = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst/res_valid", 32'(res_valid), 0);
        chk("async_rst/res_id", 32'(res_id), 0);
        chk("async_rst/res_prod", 32'(res_prod), 0);
        chk("async_rst/busy", 32'(busy), 0);
        sbq.delete();
        mptr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step("post_reset");
        req_valid = 4'b1111;
        step("first_after_reset");

        // Requester 2 withdraws while requester 1 is granted
        op_a[1] = 8'd6;  op_b[1] = 8'd7;
        op_a[3] = 8'd13; op_b[3] = 8'd17;
        req_valid = 4'b0110; step("withdraw_g1");
        req_valid = 4'b0000; step("withdraw_gap");
        req_valid = 4'b1011; step("withdraw_ptr2");
        req_valid = 4'b0000;
        repeat (4) step("withdraw_drain");

        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
`default_nettype wire
